instr_fetch: RTL and testbench

Instruction fetch stage feeding the main control decoder. Holds the PC and drives a synchronous-read instruction memory with one-cycle read latency. Delivers each instruction word and its pre-split fields (opcode, funct, register indices, shamt, immediate) to decode over a valid/ready handshake. Decode backpressure and redirects (jumps/branches) never drop or duplicate an instruction, and a full fetch rate of one instruction per cycle is sustained.

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, 1-cycle imem, out + skid slots, redirect.
// Optional accepted-instruction counter: define IF_FETCH_COUNT_EN.
module instr_fetch #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [PC_WIDTH-1:0] out_pc_plus4,
  output logic [5:0]          opcode,
  output logic [5:0]          funct,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [15:0]         imm,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [31:0]         fetch_count
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                req_pending_q, req_pending_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic       accept;
  logic       issue;
  logic       out_free;
  logic [1:0] occ;

  always_comb begin
    accept   = out_valid_q & out_ready;
    occ      = 2'(out_valid_q) + 2'(skid_valid_q)
             + 2'(req_pending_q) - 2'(accept);
    issue    = ~rst & ~redirect_valid & (occ < 2'd2);
    out_free = ~out_valid_q | accept;

    pc_d          = pc_q;
    req_pc_d      = pc_q;
    req_pending_d = issue;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;

    if (issue) pc_d = pc_q + PC_WIDTH'(4);
    if (accept) out_valid_d = 1'b0;

    if (out_free && skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_instr_d  = skid_instr_q;
      out_pc_d     = skid_pc_q;
      skid_valid_d = 1'b0;
    end

    // Arriving word goes to out only if nothing older is queued ahead
    if (req_pending_q) begin
      if (out_free && !skid_valid_q) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_rdata;
        out_pc_d    = req_pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = req_pc_q;
      end
    end

    if (redirect_valid) begin
      out_valid_d   = 1'b0;
      skid_valid_d  = 1'b0;
      req_pending_d = 1'b0;
      pc_d          = redirect_pc & ~PC_WIDTH'(3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      req_pending_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_pending_q <= req_pending_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + 32'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_count_q <= '0;
    else     fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

  assign imem_en      = issue;
  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_q + PC_WIDTH'(4);
  assign opcode       = out_instr_q[31:26];
  assign rs           = out_instr_q[25:21];
  assign rt           = out_instr_q[20:16];
  assign rd           = out_instr_q[15:11];
  assign shamt        = out_instr_q[10:6];
  assign funct        = out_instr_q[5:0];
  assign imm          = out_instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: 32-bit instance plus 8-bit wrap instance.
// Memory models return word = address (0x300 holds an R-type word).
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_count;

  logic        rst8 = 1'b1;
  logic        imem_en8;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_rdata8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [31:0] out_instr8;
  logic [7:0]  out_pc8, out_pc_plus48;
  logic [5:0]  opcode8, funct8;
  logic [4:0]  rs8, rt8, rd8, shamt8;
  logic [15:0] imm8;
  logic [31:0] fetch_count8;

  int n_checks = 0;
  int n_fail = 0;

  instr_fetch #(.PC_WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  instr_fetch #(.PC_WIDTH(8), .RESET_PC(8'hF4)) dut8 (
    .clk(clk), .rst(rst8),
    .imem_en(imem_en8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_instr(out_instr8), .out_pc(out_pc8), .out_pc_plus4(out_pc_plus48),
    .opcode(opcode8), .funct(funct8), .rs(rs8), .rt(rt8), .rd(rd8),
    .shamt(shamt8), .imm(imm8),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .fetch_count(fetch_count8)
  );

  always @(posedge clk)
    if (imem_en)
      imem_rdata <= (imem_addr == 32'h300) ? 32'h00A51820 : imem_addr;

  always @(posedge clk)
    if (imem_en8) imem_rdata8 <= {24'h0, imem_addr8};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset imem_en", 32'(imem_en), 32'd0);
    chk("reset out_instr", out_instr, 32'h0);
    chk("reset out_pc", out_pc, 32'h0);
    chk("reset fetch_count", fetch_count, 32'h0);
    rst = 1'b0;
    #1;
    chk("first issue en", 32'(imem_en), 32'd1);
    chk("first issue addr", imem_addr, 32'h100);
    tick();
    chk("out_valid after 1", 32'(out_valid), 32'd0);
    tick();
    chk("out_valid after 2", 32'(out_valid), 32'd1);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      chk("stream instr", out_instr, 32'h100 + 32'(4 * i));
      chk("stream pc", out_pc, 32'h100 + 32'(4 * i));
      chk("stream pc4", out_pc_plus4, 32'h104 + 32'(4 * i));
      if (i < 5) tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp hold instr", out_instr, 32'h114);
      chk("bp hold pc", out_pc, 32'h114);
      chk("bp imem_en low", 32'(imem_en), 32'd0);
      chk("bp out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bp resume valid", 32'(out_valid), 32'd1);
      chk("bp resume instr", out_instr, 32'h114 + 32'(4 * i));
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    tick();
    chk("rd pre instr", out_instr, 32'h120);
    chk("rd pre en", 32'(imem_en), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    #1;
    chk("rd no issue", 32'(imem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rd cleared", 32'(out_valid), 32'd0);
    chk("rd en", 32'(imem_en), 32'd1);
    chk("rd addr", imem_addr, 32'h200);
    tick();
    chk("rd bubble", 32'(out_valid), 32'd0);
    tick();
    chk("rd valid", 32'(out_valid), 32'd1);
    chk("rd pc", out_pc, 32'h200);
    chk("rd instr", out_instr, 32'h200);
    tick();
    chk("rd next", out_instr, 32'h204);
  endtask

  task automatic test_fields();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    chk("fld valid", 32'(out_valid), 32'd1);
    chk("fld pc", out_pc, 32'h300);
    chk("fld instr", out_instr, 32'h00A51820);
    chk("fld opcode", 32'(opcode), 32'd0);
    chk("fld rs", 32'(rs), 32'd5);
    chk("fld rt", 32'(rt), 32'd5);
    chk("fld rd", 32'(rd), 32'd3);
    chk("fld shamt", 32'(shamt), 32'd0);
    chk("fld funct", 32'(funct), 32'h20);
    chk("fld imm", 32'(imm), 32'h1820);
  endtask

  task automatic test_wrap_reset();
    out_ready8 = 1'b1;
    rst8 = 1'b0;
    #1;
    chk("w8 addr0", 32'(imem_addr8), 32'hF4);
    tick();
    chk("w8 addr1", 32'(imem_addr8), 32'hF8);
    tick();
    chk("w8 pc F4", 32'(out_pc8), 32'hF4);
    chk("w8 addr2", 32'(imem_addr8), 32'hFC);
    tick();
    chk("w8 wrap addr", 32'(imem_addr8), 32'h00);
    chk("w8 wrap en", 32'(imem_en8), 32'd1);
    tick();
    chk("w8 pc FC", 32'(out_pc8), 32'hFC);
    chk("w8 pc4 wrap", 32'(out_pc_plus48), 32'h00);
    tick();
    chk("w8 pc 00", 32'(out_pc8), 32'h00);
    chk("w8 instr 00", out_instr8, 32'h0);
    rst8 = 1'b1;
    #1;
    chk("w8 rst en", 32'(imem_en8), 32'd0);
    tick();
    chk("w8 rst valid", 32'(out_valid8), 32'd0);
    rst8 = 1'b0;
    #1;
    chk("w8 restart addr", 32'(imem_addr8), 32'hF4);
    tick();
    chk("w8 no stale", 32'(out_valid8), 32'd0);
    tick();
    chk("w8 restart valid", 32'(out_valid8), 32'd1);
    chk("w8 restart pc", 32'(out_pc8), 32'hF4);
  endtask

  task automatic test_counter();
    int acc = 0;
    int cyc = 0;
    logic [31:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while (acc < 10 && cyc < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) acc++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("cnt budget", 32'(acc), 32'd10);
`ifdef IF_FETCH_COUNT_EN
    exp = 32'd10;
`else
    exp = 32'd0;
`endif
    tick();
    chk("fetch_count", fetch_count, exp);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fields();
    test_wrap_reset();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
